// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: prefix bytes, receiver FSM states and key make codes.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} ps2_rx_state_t;

    // Set-2 make codes used by the keyboard command decoder
    localparam logic [7:0] KEY_0     = 8'h45;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3D;
    localparam logic [7:0] KEY_8     = 8'h3E;
    localparam logic [7:0] KEY_9     = 8'h46;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_M     = 8'h3A;
    localparam logic [7:0] KEY_N     = 8'h31;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;

    // Odd parity holds when data plus parity bit contain an odd number of ones
    function automatic logic parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises a raw PS/2 line, rejects short glitches and pulses on accepted falling edges.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic line,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level;
    logic [CW-1:0]          cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            level  <= 1'b1;
            cnt    <= '0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            fall   <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // FILTER_LEN consecutive differing samples: accept the new level
                level <= synced;
                cnt   <= '0;
                fall  <= !synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: deserialises frames, folds E0/F0 prefixes, reports key codes.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit PASS_BREAK     = 1'b0
) (
    input  logic          clk_in,
    input  logic          reset_n,
    input  logic          ps2_clock,
    input  logic          ps2_data,
    output logic [7:0]    scancode,
    output logic          valid,
    output logic          extended,
    output logic          is_break,
    output logic          frame_err,
    output logic [7:0]    err_count,
    output ps2_rx_state_t rx_state
);

    // valid is a one-cycle pulse with no backpressure: scancode/extended/is_break are
    // meaningful in the valid cycle and hold until the next one.

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    ps2_rx_state_t          state;
    logic [SYNC_STAGES-1:0] data_q;
    logic                   data_s;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic [9:0]             shreg;
    logic [TW-1:0]          timer;
    logic                   break_pend;
    logic                   ext_pend;
    logic                   timeout;
    logic                   check_bad;
    logic                   err_now;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .line    (ps2_clock),
        .fall    (fall)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) data_q <= '1;
        else          data_q <= {data_q[SYNC_STAGES-2:0], ps2_data};
    end
    assign data_s   = data_q[SYNC_STAGES-1];
    assign rx_state = state;

    always_comb begin
        timeout   = (state == RECV) && !fall && (timer == TMAX);
        check_bad = (state == CHECK) && (!parity_ok(shreg[8:0]) || !shreg[9]);
        err_now   = ((state == IDLE) && fall && data_s) || timeout || check_bad;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            timer      <= '0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            scancode   <= '0;
            extended   <= 1'b0;
            is_break   <= 1'b0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= err_now;
            if (err_now && err_count != 8'hFF) err_count <= err_count + 1'b1;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (fall && !data_s) begin
                        bit_cnt <= 4'd1;
                        shreg   <= '0;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (fall) begin
                        // LSB first: after ten shifts shreg = {stop, parity, data[7:0]}
                        shreg   <= {data_s, shreg[9:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        timer   <= '0;
                        if (bit_cnt == 4'd10) state <= CHECK;
                    end else if (timeout) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        break_pend <= 1'b0;
                        ext_pend   <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    if (check_bad) begin
                        break_pend <= 1'b0;
                        ext_pend   <= 1'b0;
                    end else if (shreg[7:0] == PS2_BREAK) begin
                        break_pend <= 1'b1;
                    end else if (shreg[7:0] == PS2_EXT) begin
                        ext_pend <= 1'b1;
                    end else begin
                        // Suppressed break codes leave the last reported code untouched
                        if (!break_pend || PASS_BREAK) begin
                            scancode <= shreg[7:0];
                            extended <= ext_pend;
                            is_break <= break_pend;
                            valid    <= 1'b1;
                        end
                        break_pend <= 1'b0;
                        ext_pend   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed PS/2 frames, expected codes queued, monitor checks outputs.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int HALF    = 10;
    localparam int TIMEOUT = 1000;

    logic          clk_in = 1'b0;
    logic          reset_n = 1'b0;
    logic          ps2_clock = 1'b1;
    logic          ps2_data = 1'b1;
    logic [7:0]    scancode;
    logic          valid;
    logic          extended;
    logic          is_break;
    logic          frame_err;
    logic [7:0]    err_count;
    ps2_rx_state_t rx_state;

    logic [9:0] exp_q[$];   // {extended, is_break, scancode}
    logic [7:0] err_q[$];   // err_count expected at each frame_err pulse
    int n_cmp = 0;
    int n_err = 0;

    ps2_scancode_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TIMEOUT),
        .PASS_BREAK     (1'b0)
    ) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .scancode  (scancode),
        .valid     (valid),
        .extended  (extended),
        .is_break  (is_break),
        .frame_err (frame_err),
        .err_count (err_count),
        .rx_state  (rx_state)
    );

    // clock / reset
    always #10 clk_in = ~clk_in;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // drivers
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cycles(HALF);
            ps2_clock = 1'b0;
            cycles(HALF);
            ps2_clock = 1'b1;
        end
        cycles(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11);
        cycles(40);
    endtask

    task automatic expect_code(input logic ext, input logic [7:0] code);
        exp_q.push_back({ext, 1'b0, code});
    endtask

    // scoreboard monitor
    always @(negedge clk_in) begin
        if (reset_n) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got code %0h, no code expected", scancode);
                end else begin
                    check("valid_code", {22'd0, extended, is_break, scancode}, {22'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame_err: got err_count %0d, no error expected", err_count);
                end else begin
                    check("err_count", {24'd0, err_count}, {24'd0, err_q.pop_front()});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        @(negedge clk_in);
        check({tag, "_scancode"}, {24'd0, scancode}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_extended"}, {31'd0, extended}, 32'd0);
        check({tag, "_is_break"}, {31'd0, is_break}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
        check({tag, "_state"}, {30'd0, rx_state}, {30'd0, IDLE});
    endtask

    initial begin
        cycles(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        cycles(20);

        // plain make code
        expect_code(1'b0, KEY_A);
        send_frame(8'h1C, 1'b0);

        // break of A suppressed, then Enter
        send_frame(PS2_BREAK, 1'b0);
        send_frame(8'h1C, 1'b0);
        expect_code(1'b0, KEY_ENTER);
        send_frame(8'h5A, 1'b0);

        // extended prefix, repeated prefix, then plain code
        expect_code(1'b1, 8'h75);
        send_frame(PS2_EXT, 1'b0);
        send_frame(8'h75, 1'b0);
        expect_code(1'b1, 8'h74);
        send_frame(PS2_EXT, 1'b0);
        send_frame(PS2_EXT, 1'b0);
        send_frame(8'h74, 1'b0);
        expect_code(1'b0, KEY_W);
        send_frame(8'h1D, 1'b0);

        // parity error after E0 clears the pending prefix
        send_frame(PS2_EXT, 1'b0);
        err_q.push_back(8'd1);
        send_frame(8'h2D, 1'b1);
        expect_code(1'b0, KEY_W);
        send_frame(8'h1D, 1'b0);

        // stalled frame times out, next frame decodes
        err_q.push_back(8'd2);
        send_bits(11'b000_0001_0110 << 0, 5);
        cycles(TIMEOUT + 200);
        expect_code(1'b0, KEY_1);
        send_frame(8'h16, 1'b0);

        // start bit sampled high
        err_q.push_back(8'd3);
        send_bits(11'h7FF, 1);
        cycles(40);

        // short low glitches on the clock line
        for (int g = 0; g < 5; g++) begin
            ps2_clock = 1'b0;
            cycles(2);
            ps2_clock = 1'b1;
            cycles(15);
        end
        expect_code(1'b0, KEY_S);
        send_frame(8'h1B, 1'b0);

        // reset in the middle of a frame
        send_bits(11'b000_0010_0110, 5);
        ps2_clock = 1'b0;
        cycles(3);
        #3 reset_n = 1'b0;
        check_all_zero("midreset");
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
        cycles(5);
        reset_n = 1'b1;
        cycles(20);
        expect_code(1'b0, KEY_D);
        send_frame(8'h23, 1'b0);

        for (int i = 0; i < 200 && (exp_q.size() != 0 || err_q.size() != 0); i++) cycles(1);
        check("codes_left", exp_q.size(), 32'd0);
        check("errors_left", err_q.size(), 32'd0);
        check("final_err_count", {24'd0, err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
